// File: rtl/clock_time_controller_pkg.sv
// Shared definitions for the clock time controller: mode encodings, field limits and widths.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package clock_time_controller_pkg;

    // Field widths of the time counters
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 4;

    // Largest legal value of each field before it wraps to zero
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 4'd11;

    // User mode; the numeric values are visible on the mode output
    typedef enum logic [1:0] {
        MODE_RUN        = 2'd0,
        MODE_SET_HOUR   = 2'd1,
        MODE_SET_MINUTE = 2'd2
    } mode_t;

    // Modulo increment shared by all three fields (hours are zero-extended by the caller)
    function automatic logic [5:0] incWrap(input logic [5:0] val, input logic [5:0] maxVal);
        return (val == maxVal) ? 6'd0 : val + 6'd1;
    endfunction

endpackage

// File: rtl/clock_time_controller_tick_prescaler.sv
// Prescaler: divides cmosClock by TICK_DIV and emits a one-cycle registered wrap pulse.
// Latency: wrap is registered on the edge where the count leaves TICK_DIV-1.
// Backpressure: none; enable low or clear high holds the count at 0 and suppresses wrap.
module tick_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic cmosClock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic wrap
);

    // A divide-by-one still needs a one-bit counter to stay legal
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    // Count 0..TICK_DIV-1; wrap is flagged on the cycle the counter returns to zero
    always_ff @(posedge cmosClock) begin
        if (reset || clear || !enable) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (count == LAST) begin
            count <= '0;
            wrap  <= 1'b1;
        end else begin
            count <= count + 1'b1;
            wrap  <= 1'b0;
        end
    end

endmodule

// File: rtl/clock_time_controller.sv
// Timekeeping controller: 1 Hz scheduler driving cascaded sec/min/hour counters plus a set-time FSM.
// Latency: button level to field/mode update is two edges; prescaler wrap to count/tick is one edge.
// Backpressure: none; all outputs are registered and the consumers must accept every tick.
module clock_time_controller
    import clock_time_controller_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic              cmosClock,
    input  logic              reset,
    input  logic              btnMode,
    input  logic              btnInc,
    output logic [SEC_W-1:0]  seconds,
    output logic [MIN_W-1:0]  minutes,
    output logic [HOUR_W-1:0] hours,
    output logic              secondTick,
    output logic              minuteTick,
    output logic              hourTick,
    output logic [1:0]        mode
);

    mode_t modeState;

    logic modeLvl;
    logic modePrev;
    logic incLvl;
    logic incPrev;
    logic lvlValid;
    logic prevValid;

    logic modeEdge;
    logic incEdge;

    logic psEnable;
    logic psClear;
    logic psWrap;

    // Register each button level once and keep one cycle of history. The valid
    // pair marks when the history holds a real sample rather than the reset
    // value, so a button held through reset release does not look like a press.
    always_ff @(posedge cmosClock) begin
        if (reset) begin
            modeLvl   <= 1'b0;
            modePrev  <= 1'b0;
            incLvl    <= 1'b0;
            incPrev   <= 1'b0;
            lvlValid  <= 1'b0;
            prevValid <= 1'b0;
        end else begin
            modeLvl   <= btnMode;
            modePrev  <= modeLvl;
            incLvl    <= btnInc;
            incPrev   <= incLvl;
            lvlValid  <= 1'b1;
            prevValid <= lvlValid;
        end
    end

    assign modeEdge = modeLvl & ~modePrev & prevValid;
    assign incEdge  = incLvl & ~incPrev & prevValid;

    // The prescaler runs in RUN (and free-runs harmlessly in SET_MINUTE, where
    // its wraps are ignored). A mode edge out of RUN drops the partial count;
    // leaving SET_MINUTE clears it so time restarts on a whole minute.
    always_comb begin
        psEnable = 1'b0;
        case (modeState)
            MODE_RUN:        psEnable = ~modeEdge;
            MODE_SET_HOUR:   psEnable = 1'b0;
            MODE_SET_MINUTE: psEnable = 1'b1;
            default:         psEnable = 1'b0;
        endcase
    end

    assign psClear = modeEdge && (modeState == MODE_SET_MINUTE);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) uPrescaler (
        .cmosClock (cmosClock),
        .reset     (reset),
        .enable    (psEnable),
        .clear     (psClear),
        .wrap      (psWrap)
    );

    // Mode FSM with the cascaded field counters and tick pulses. A mode edge
    // always takes priority over a coincident increment or prescaler wrap.
    always_ff @(posedge cmosClock) begin
        if (reset) begin
            modeState  <= MODE_RUN;
            seconds    <= '0;
            minutes    <= '0;
            hours      <= '0;
            secondTick <= 1'b0;
            minuteTick <= 1'b0;
            hourTick   <= 1'b0;
        end else begin
            secondTick <= 1'b0;
            minuteTick <= 1'b0;
            hourTick   <= 1'b0;
            case (modeState)
                MODE_RUN: begin
                    if (modeEdge) begin
                        modeState <= MODE_SET_HOUR;
                    end else if (psWrap) begin
                        seconds    <= incWrap(seconds, SEC_MAX);
                        secondTick <= 1'b1;
                        if (seconds == SEC_MAX) begin
                            minutes    <= incWrap(minutes, MIN_MAX);
                            minuteTick <= 1'b1;
                            if (minutes == MIN_MAX) begin
                                hours    <= HOUR_W'(incWrap({2'b00, hours}, {2'b00, HOUR_MAX}));
                                hourTick <= 1'b1;
                            end
                        end
                    end
                end
                MODE_SET_HOUR: begin
                    if (modeEdge) begin
                        modeState <= MODE_SET_MINUTE;
                    end else if (incEdge) begin
                        hours    <= HOUR_W'(incWrap({2'b00, hours}, {2'b00, HOUR_MAX}));
                        hourTick <= 1'b1;
                    end
                end
                MODE_SET_MINUTE: begin
                    if (modeEdge) begin
                        modeState <= MODE_RUN;
                        seconds   <= '0;
                    end else if (incEdge) begin
                        minutes    <= incWrap(minutes, MIN_MAX);
                        minuteTick <= 1'b1;
                    end
                end
                default: begin
                    modeState <= MODE_RUN;
                end
            endcase
        end
    end

    assign mode = modeState;

endmodule

// File: tb/tb_clock_time_controller.sv
// Bench for clock_time_controller with TICK_DIV = 10: table rows plus press sequences.
// Latency: each row holds its inputs for a number of edges, then checks outputs at the next negedge.
// Backpressure: none; expected values are queued when a row is driven and popped when it is checked.
module tb_clock_time_controller;

    logic       cmosClock = 1'b0;
    logic       reset;
    logic       btnMode;
    logic       btnInc;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [3:0] hours;
    logic       secondTick;
    logic       minuteTick;
    logic       hourTick;
    logic [1:0] mode;

    typedef struct {
        string      name;
        bit         rst;
        bit         bm;
        bit         bi;
        int         cyc;
        logic [5:0] s;
        logic [5:0] m;
        logic [3:0] h;
        logic [2:0] tk;   // {secondTick, minuteTick, hourTick}
        logic [1:0] md;
    } vec_t;

    vec_t tbl[$];
    vec_t expQ[$];
    int   checks;
    int   failures;

    always #5 cmosClock = ~cmosClock;

    clock_time_controller #(
        .TICK_DIV (10)
    ) dut (
        .cmosClock  (cmosClock),
        .reset      (reset),
        .btnMode    (btnMode),
        .btnInc     (btnInc),
        .seconds    (seconds),
        .minutes    (minutes),
        .hours      (hours),
        .secondTick (secondTick),
        .minuteTick (minuteTick),
        .hourTick   (hourTick),
        .mode       (mode)
    );

    function automatic vec_t mk(input string nm, input bit r, input bit bm, input bit bi,
                                input int cyc, input int s, input int m, input int h,
                                input bit st, input bit mt, input bit ht, input int md);
        vec_t v;
        v.name = nm;
        v.rst  = r;
        v.bm   = bm;
        v.bi   = bi;
        v.cyc  = cyc;
        v.s    = 6'(s);
        v.m    = 6'(m);
        v.h    = 4'(h);
        v.tk   = {st, mt, ht};
        v.md   = 2'(md);
        return v;
    endfunction

    // Drive one row for v.cyc edges (called at a negedge), then check the result
    task automatic apply(input vec_t v);
        vec_t e;
        reset   = v.rst;
        btnMode = v.bm;
        btnInc  = v.bi;
        expQ.push_back(v);
        repeat (v.cyc) begin
            @(posedge cmosClock);
            @(negedge cmosClock);
        end
        e = expQ.pop_front();
        checks++;
        if ({seconds, minutes, hours, secondTick, minuteTick, hourTick, mode} !==
            {e.s, e.m, e.h, e.tk, e.md}) begin
            failures++;
            $display("FAIL %s: got s=%0d m=%0d h=%0d ticks=%b mode=%0d, expected s=%0d m=%0d h=%0d ticks=%b mode=%0d",
                     e.name, seconds, minutes, hours, {secondTick, minuteTick, hourTick}, mode,
                     e.s, e.m, e.h, e.tk, e.md);
        end
    endtask

    task automatic runTbl();
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
        tbl.delete();
    endtask

    // btnInc press held two edges (event on the second), then released for one edge
    task automatic pressInc(input string nm, input int s, input int m, input int h,
                            input bit mt, input bit ht, input int md);
        apply(mk(nm, 0, 0, 1, 2, s, m, h, 0, mt, ht, md));
        apply(mk({nm, "_release"}, 0, 0, 0, 1, s, m, h, 0, 0, 0, md));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        btnMode  = 1'b0;
        btnInc   = 1'b0;
        @(negedge cmosClock);

        // Reset values, first tick timing and period, then enter SET_HOUR at 0:00:37
        tbl.push_back(mk("reset_values",     1, 0, 0,   2,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("before_first_tick",0, 0, 0,   9,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("wrap_registered",  0, 0, 0,   1,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("first_tick",       0, 0, 0,   1,  1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk("tick_one_cycle",   0, 0, 0,   1,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("between_ticks",    0, 0, 0,   8,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("second_tick",      0, 0, 0,   1,  2, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk("run_to_37",        0, 0, 0, 350, 37, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk("enter_set_hour",   0, 1, 0,   2, 37, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk("mode_release",     0, 0, 0,   1, 37, 0, 0, 0, 0, 0, 1));
        runTbl();

        // SET_HOUR: step to 9, then 10, 11, 0 with hourTick, then a long hold
        for (int i = 1; i <= 9; i++) pressInc("hour_inc", 37, 0, i, 0, 1, 1);
        tbl.push_back(mk("hour_to_10",       0, 0, 1,   2, 37, 0, 10, 0, 0, 1, 1));
        tbl.push_back(mk("hour_10_release",  0, 0, 0,   1, 37, 0, 10, 0, 0, 0, 1));
        tbl.push_back(mk("hour_to_11",       0, 0, 1,   2, 37, 0, 11, 0, 0, 1, 1));
        tbl.push_back(mk("hour_11_release",  0, 0, 0,   1, 37, 0, 11, 0, 0, 0, 1));
        tbl.push_back(mk("hour_wrap_to_0",   0, 0, 1,   2, 37, 0,  0, 0, 0, 1, 1));
        tbl.push_back(mk("hour_0_release",   0, 0, 0,   1, 37, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk("hold_one_event",   0, 0, 1,   6, 37, 0,  1, 0, 0, 0, 1));
        tbl.push_back(mk("hold_release",     0, 0, 0,   1, 37, 0,  1, 0, 0, 0, 1));
        runTbl();
        for (int i = 2; i <= 11; i++) pressInc("hour_inc", 37, 0, i, 0, 1, 1);

        // Simultaneous mode and inc edges: mode wins, hours untouched
        apply(mk("mode_beats_inc",      0, 1, 1, 2, 37, 0, 11, 0, 0, 0, 2));
        apply(mk("mode_beats_inc_rel",  0, 0, 0, 1, 37, 0, 11, 0, 0, 0, 2));

        // SET_MINUTE: step to 59, wrap to 0 without carry, back up to 59
        for (int i = 1; i <= 59; i++) pressInc("min_inc", 37, i, 11, 1, 0, 2);
        pressInc("min_wrap_no_carry", 37, 0, 11, 1, 0, 2);
        for (int i = 1; i <= 59; i++) pressInc("min_inc", 37, i, 11, 1, 0, 2);

        // Leave SET_MINUTE: seconds cleared, whole-minute restart, run to the full cascade,
        // then a btnMode edge coincident with a prescaler wrap
        tbl.push_back(mk("exit_set_minute",  0, 1, 0,   2,  0, 59, 11, 0, 0, 0, 0));
        tbl.push_back(mk("exit_release",     0, 0, 0,   1,  0, 59, 11, 0, 0, 0, 0));
        tbl.push_back(mk("restart_quiet",    0, 0, 0,   8,  0, 59, 11, 0, 0, 0, 0));
        tbl.push_back(mk("restart_wrap_reg", 0, 0, 0,   1,  0, 59, 11, 0, 0, 0, 0));
        tbl.push_back(mk("restart_tick",     0, 0, 0,   1,  1, 59, 11, 1, 0, 0, 0));
        tbl.push_back(mk("run_to_11_59_59",  0, 0, 0, 580, 59, 59, 11, 1, 0, 0, 0));
        tbl.push_back(mk("hold_11_59_59",    0, 0, 0,   9, 59, 59, 11, 0, 0, 0, 0));
        tbl.push_back(mk("full_cascade",     0, 0, 0,   1,  0,  0,  0, 1, 1, 1, 0));
        tbl.push_back(mk("cascade_ticks_end",0, 0, 0,   1,  0,  0,  0, 0, 0, 0, 0));
        tbl.push_back(mk("pre_collision",    0, 0, 0,   7,  0,  0,  0, 0, 0, 0, 0));
        tbl.push_back(mk("mode_beats_wrap",  0, 1, 0,   2,  0,  0,  0, 0, 0, 0, 1));
        tbl.push_back(mk("collision_release",0, 0, 0,   1,  0,  0,  0, 0, 0, 0, 1));
        tbl.push_back(mk("to_set_minute",    0, 1, 0,   2,  0,  0,  0, 0, 0, 0, 2));
        tbl.push_back(mk("to_set_min_rel",   0, 0, 0,   1,  0,  0,  0, 0, 0, 0, 2));
        runTbl();

        // Reset in SET_MINUTE with btnInc held across it
        pressInc("min_before_reset", 0, 1, 0, 1, 0, 2);
        tbl.push_back(mk("inc_rising",       0, 0, 1,   1,  0,  1,  0, 0, 0, 0, 2));
        tbl.push_back(mk("reset_mid_op",     1, 0, 1,   1,  0,  0,  0, 0, 0, 0, 0));
        tbl.push_back(mk("post_reset_held",  0, 0, 1,   3,  0,  0,  0, 0, 0, 0, 0));
        tbl.push_back(mk("set_hour_held_inc",0, 1, 1,   2,  0,  0,  0, 0, 0, 0, 1));
        tbl.push_back(mk("held_inc_no_event",0, 0, 1,   3,  0,  0,  0, 0, 0, 0, 1));
        tbl.push_back(mk("final_release",    0, 0, 0,   1,  0,  0,  0, 0, 0, 0, 1));
        runTbl();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
